// File: rtl/piso_frame_tx.sv
// -----------------------------------------------------------------------------
// piso_frame_tx
//
// Transmit end of the serial bit-stream link. A parallel word is accepted over
// a valid/ready handshake, framed, and shifted out at one bit per clock on op:
//   start bit (0), WIDTH data bits, optional even-parity bit, stop bit (1).
// The line idles high. Every output is a flop; nothing from load/din reaches
// op combinationally.
//
// Parameters
//   WIDTH      data bits per frame (>= 2)
//   MSB_FIRST  1: din[WIDTH-1] goes out first, 0: din[0] goes out first
//   PARITY_EN  1: even-parity bit follows the data, 0: no parity bit
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-low reset (0 = reset)
//   din    in   parallel word, sampled only on the accept edge
//   load   in   producer valid
//   ready  out  block can accept a word (IDLE only)
//   op     out  serial line, idle high
//   busy   out  frame in progress (START..STOP)
//   done   out  high for exactly the STOP-bit cycle
// -----------------------------------------------------------------------------
module piso_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             op,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             par_q,   par_d;
  logic             op_q,    op_d;
  logic             ready_q, ready_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Bit that goes out next, and the register after that bit is consumed.
  // The vacated end fills with zeros so the register drains to 0.
  logic             head;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (MSB_FIRST != 0) begin
      head    = shreg_q[WIDTH-1];
      shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      head    = shreg_q[0];
      shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  // Outputs are registered, so each branch sets the value op/ready/busy/done
  // must carry during the state being entered, not the current one.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    op_d    = op_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          // Accept point: capture the word and its even parity.
          state_d = S_START;
          shreg_d = din;
          par_d   = ^din;
          cnt_d   = '0;
          op_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        // Present data bit 0 and consume it from the register.
        state_d = S_DATA;
        op_d    = head;
        shreg_d = shifted;
        cnt_d   = '0;
      end

      S_DATA: begin
        // cnt_q is the index of the data bit currently on op.
        if (cnt_q == CNT_LAST) begin
          if (PARITY_EN != 0) begin
            state_d = S_PARITY;
            op_d    = par_q;
          end else begin
            state_d = S_STOP;
            op_d    = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          op_d    = head;
          shreg_d = shifted;
        end
      end

      S_PARITY: begin
        state_d = S_STOP;
        op_d    = 1'b1;
        done_d  = 1'b1;
      end

      S_STOP: begin
        state_d = S_IDLE;
        op_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        op_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset aborts any frame at once and forces the line high without a low
  // glitch, since op_q itself is set to 1 asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      op_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      op_q    <= op_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign op    = op_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_frame_tx
//
// Three instances of piso_frame_tx share clk and reset:
//   0: WIDTH=8, MSB_FIRST=1, PARITY_EN=1
//   1: WIDTH=8, MSB_FIRST=0, PARITY_EN=1
//   2: WIDTH=8, MSB_FIRST=1, PARITY_EN=0
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_piso_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din_v [3];
  logic [2:0] load_v = '0;
  logic [2:0] ready_v, op_v, busy_v, done_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_frame_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) u_msb (
    .clk(clk), .reset(reset), .din(din_v[0]), .load(load_v[0]),
    .ready(ready_v[0]), .op(op_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  piso_frame_tx #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(1)) u_lsb (
    .clk(clk), .reset(reset), .din(din_v[1]), .load(load_v[1]),
    .ready(ready_v[1]), .op(op_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  piso_frame_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) u_nopar (
    .clk(clk), .reset(reset), .din(din_v[2]), .load(load_v[2]),
    .ready(ready_v[2]), .op(op_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  typedef struct {
    int          dut;
    logic [7:0]  din;
    logic [0:15] frame;   // frame[0] is the first bit on the line
    int          flen;
    int          glitch;  // frame index at which a stray load is pulsed, -1 none
    string       name;
  } vec_t;

  task automatic chk(input string nm, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", nm, what, act, exp);
    end
  endtask

  // Frame built straight from the framing rules.
  function automatic void model_frame(input logic [7:0] d, input bit msb,
                                      input bit par, output logic [0:15] f,
                                      output int n);
    f    = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = msb ? d[7-i] : d[i];
    n = 9;
    if (par) begin
      f[n] = ($countones(d) % 2) == 1;
      n++;
    end
    f[n] = 1'b1;
    n++;
  endfunction

  task automatic run_frame(input int w, input logic [7:0] d,
                           input logic [0:15] exp_f, input int n,
                           input int glitch_at, input string nm);
    int t;
    t = 0;
    while (ready_v[w] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk(nm, "ready_before", 32'(ready_v[w]), 32'd1);
    din_v[w]  = d;
    load_v[w] = 1'b1;
    @(negedge clk);
    load_v[w] = 1'b0;
    din_v[w]  = ~d;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      chk(nm, $sformatf("op_bit%0d", k), 32'(op_v[w]), 32'(exp_f[k]));
      chk(nm, $sformatf("busy_ready_done%0d", k),
          32'({busy_v[w], ready_v[w], done_v[w]}),
          32'({1'b1, 1'b0, (k == n - 1)}));
      if (glitch_at >= 0 && k == glitch_at) begin
        din_v[w]  = 8'hFF;
        load_v[w] = 1'b1;
      end else if (glitch_at >= 0 && k == glitch_at + 1) begin
        load_v[w] = 1'b0;
      end
    end
    @(negedge clk);
    load_v[w] = 1'b0;
    chk(nm, "op_after", 32'(op_v[w]), 32'd1);
    chk(nm, "busy_ready_done_after",
        32'({busy_v[w], ready_v[w], done_v[w]}), 32'b010);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    logic [0:15] f, fa, fb;
    int          n;
    logic [0:23] line;

    for (int i = 0; i < 3; i++) din_v[i] = 8'h00;

    vecs[0] = '{0, 8'hA5, 16'b0101_0010_1010_0000, 11, -1, "a5"};
    vecs[1] = '{0, 8'h07, 16'b0000_0011_1110_0000, 11, -1, "07_msb"};
    vecs[2] = '{1, 8'h07, 16'b0111_0000_0110_0000, 11, -1, "07_lsb"};
    vecs[3] = '{2, 8'hC3, 16'b0110_0001_1100_0000, 10, -1, "c3_nopar"};
    vecs[4] = '{0, 8'h3C, 16'b0001_1110_0010_0000, 11,  4, "3c_ignore_load"};
    vecs[5] = '{0, 8'hFF, 16'b0111_1111_1010_0000, 11, -1, "ff"};
    vecs[6] = '{0, 8'h00, 16'b0000_0000_0010_0000, 11, -1, "00"};
    vecs[7] = '{1, 8'h80, 16'b0000_0000_1110_0000, 11, -1, "80_lsb"};

    // Reset values
    @(negedge clk);
    load_v = '1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_dut%0d", i), "op", 32'(op_v[i]), 32'd1);
      chk($sformatf("reset_dut%0d", i), "busy_ready_done",
          32'({busy_v[i], ready_v[i], done_v[i]}), 32'b010);
    end
    load_v = '0;
    reset  = 1'b1;
    @(negedge clk);

    // Directed table
    foreach (vecs[i])
      run_frame(vecs[i].dut, vecs[i].din, vecs[i].frame, vecs[i].flen,
                vecs[i].glitch, vecs[i].name);

    // Back-to-back with load held high: 81 then 7E, one idle bit between
    fa = 16'b0100_0000_1010_0000;
    fb = 16'b0011_1111_0010_0000;
    din_v[0]  = 8'h81;
    load_v[0] = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      line[k] = op_v[0];
      if (k == 0) din_v[0] = 8'h7E;
      if (k == 11) chk("b2b", "ready_gap", 32'(ready_v[0]), 32'd1);
      if (k == 12) load_v[0] = 1'b0;
    end
    chk("b2b", "line", 32'(line), 32'({fa[0:10], 1'b1, fb[0:10], 1'b1}));

    // Reset in the middle of a frame
    @(negedge clk);
    din_v[0]  = 8'h55;
    load_v[0] = 1'b1;
    @(negedge clk);
    load_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("midreset", "op_before", 32'(op_v[0]), 32'd0);
    chk("midreset", "busy_before", 32'(busy_v[0]), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midreset", "op_now", 32'(op_v[0]), 32'd1);
    chk("midreset", "busy_ready_done_now",
        32'({busy_v[0], ready_v[0], done_v[0]}), 32'b010);
    din_v[0]  = 8'hAA;
    load_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset", "op_held", 32'(op_v[0]), 32'd1);
    load_v[0] = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    chk("midreset", "no_frame_after_release",
        32'({op_v[0], busy_v[0], ready_v[0]}), 32'b101);
    run_frame(0, 8'h0F, 16'b0000_0111_1010_0000, 11, -1, "0f_after_reset");

    // Randomized frames against the model
    for (int i = 0; i < 60; i++) begin
      int         w;
      logic [7:0] d;
      w = i % 3;
      d = 8'($urandom);
      model_frame(d, w != 1, w != 2, f, n);
      run_frame(w, d, f, n, -1, $sformatf("rand%0d_dut%0d_%02h", i, w, d));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
